// File: rtl/cpu_exec_ctrl_if.sv
// Instruction issue channel between pin decode and the execution controller.
// The master presents a decoded instruction; the slave accepts it with inst_ready.
interface cpu_exec_ctrl_if #(
    parameter int unsigned RA = 4,
    parameter int unsigned BW = 8
);
    logic          inst_valid;
    logic          inst_ready;
    logic [3:0]    inst_op;
    logic [RA-1:0] inst_r1;
    logic [RA-1:0] inst_r2;
    logic [RA-1:0] inst_r3;
    logic [BW-1:0] inst_data;

    modport master (
        output inst_valid, inst_op, inst_r1, inst_r2, inst_r3, inst_data,
        input  inst_ready
    );

    modport slave (
        input  inst_valid, inst_op, inst_r1, inst_r2, inst_r3, inst_data,
        output inst_ready
    );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Multi-cycle execution controller: sequences register file reads/writes and the ALU
// for one instruction at a time, and owns the status bit and the data output register.
module cpu_exec_ctrl #(
    parameter int unsigned BIT_WIDTH_REG = 8,
    parameter int unsigned REG_COUNT     = 16,
    localparam int unsigned RA           = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    cpu_exec_ctrl_if.slave           inst_if,
    output logic                     rf_write,
    output logic [RA-1:0]            rf_w_reg,
    output logic [BIT_WIDTH_REG-1:0] rf_w_d,
    output logic [RA-1:0]            rf_r_reg1,
    output logic [RA-1:0]            rf_r_reg2,
    input  logic [BIT_WIDTH_REG-1:0] rf_r_d1,
    input  logic [BIT_WIDTH_REG-1:0] rf_r_d2,
    output logic [2:0]               alu_op,
    output logic [BIT_WIDTH_REG-1:0] alu_in1,
    output logic [BIT_WIDTH_REG-1:0] alu_in2,
    input  logic [BIT_WIDTH_REG-1:0] alu_out,
    input  logic                     alu_c,
    output logic [BIT_WIDTH_REG-1:0] data_out,
    output logic                     data_out_valid,
    output logic                     status,
    output logic                     illegal
);
    localparam int unsigned BW = BIT_WIDTH_REG;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

    function automatic logic is_mvr(input logic [3:0] op); return op == 4'b0000; endfunction
    function automatic logic is_ldb(input logic [3:0] op); return op == 4'b0001; endfunction
    function automatic logic is_stb(input logic [3:0] op); return op == 4'b0010; endfunction
    function automatic logic is_rds(input logic [3:0] op); return op == 4'b0011; endfunction
    function automatic logic is_alu(input logic [3:0] op); return op[3] && (op != 4'b1111); endfunction
    function automatic logic is_ill(input logic [3:0] op);
        return (!op[3] && op[2]) || (op == 4'b1111);
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [RA-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [BW-1:0] imm_q, imm_d;
    logic [BW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic          carry_q, carry_d;
    logic [BW-1:0] data_out_q, data_out_d;
    logic          dov_q, dov_d;
    logic          status_q, status_d;
    logic          illegal_q, illegal_d;
    logic          inst_ready_q, inst_ready_d;
    logic          rf_write_q, rf_write_d;
    logic [RA-1:0] rf_w_reg_q, rf_w_reg_d;
    logic [BW-1:0] rf_w_d_q, rf_w_d_d;
    logic [RA-1:0] rf_r_reg1_q, rf_r_reg1_d;
    logic [RA-1:0] rf_r_reg2_q, rf_r_reg2_d;

    // Sequencing and datapath capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        imm_d      = imm_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        carry_d    = carry_q;
        data_out_d = data_out_q;
        status_d   = status_q;
        dov_d      = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inst_if.inst_valid) begin
                    op_d    = inst_if.inst_op;
                    r1_d    = inst_if.inst_r1;
                    r2_d    = inst_if.inst_r2;
                    r3_d    = inst_if.inst_r3;
                    imm_d   = inst_if.inst_data;
                    state_d = (is_mvr(inst_if.inst_op) || is_stb(inst_if.inst_op) ||
                               is_alu(inst_if.inst_op)) ? S_RD : S_WB;
                end
            end
            S_RD: begin
                a_d     = rf_r_d1;
                b_d     = rf_r_d2;
                state_d = is_alu(op_q) ? S_EX : S_WB;
            end
            S_EX: begin
                res_d   = alu_out;
                carry_d = alu_c;
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (is_stb(op_q)) begin
                    data_out_d = a_q;
                    dov_d      = 1'b1;
                end
                if (is_rds(op_q)) begin
                    data_out_d = BW'(status_q);
                    dov_d      = 1'b1;
                end
                if (is_alu(op_q)) status_d  = carry_q;
                if (is_ill(op_q)) illegal_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port values are registered from the next-state view so they line up with state_q
    always_comb begin
        inst_ready_d = (state_d == S_IDLE);
        rf_write_d   = (state_d == S_WB) && (is_mvr(op_d) || is_ldb(op_d) || is_alu(op_d));
        rf_w_reg_d   = is_mvr(op_d) ? r2_d : r1_d;
        rf_w_d_d     = is_mvr(op_d) ? a_d : (is_ldb(op_d) ? imm_d : res_d);
        rf_r_reg1_d  = (is_mvr(op_d) || is_stb(op_d)) ? r1_d : r2_d;
        rf_r_reg2_d  = r3_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            r3_q         <= '0;
            imm_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            data_out_q   <= '0;
            dov_q        <= 1'b0;
            status_q     <= 1'b0;
            illegal_q    <= 1'b0;
            inst_ready_q <= 1'b1;
            rf_write_q   <= 1'b0;
            rf_w_reg_q   <= '0;
            rf_w_d_q     <= '0;
            rf_r_reg1_q  <= '0;
            rf_r_reg2_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            r3_q         <= r3_d;
            imm_q        <= imm_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            data_out_q   <= data_out_d;
            dov_q        <= dov_d;
            status_q     <= status_d;
            illegal_q    <= illegal_d;
            inst_ready_q <= inst_ready_d;
            rf_write_q   <= rf_write_d;
            rf_w_reg_q   <= rf_w_reg_d;
            rf_w_d_q     <= rf_w_d_d;
            rf_r_reg1_q  <= rf_r_reg1_d;
            rf_r_reg2_q  <= rf_r_reg2_d;
        end
    end

    assign inst_if.inst_ready = inst_ready_q;
    assign rf_write           = rf_write_q;
    assign rf_w_reg           = rf_w_reg_q;
    assign rf_w_d             = rf_w_d_q;
    assign rf_r_reg1          = rf_r_reg1_q;
    assign rf_r_reg2          = rf_r_reg2_q;
    assign alu_op             = op_q[2:0];
    assign alu_in1            = a_q;
    assign alu_in2            = b_q;
    assign data_out           = data_out_q;
    assign data_out_valid     = dov_q;
    assign status             = status_q;
    assign illegal            = illegal_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Bench for cpu_exec_ctrl: register file and ALU stubs around the DUT, checked against
// an instruction-level architectural model (registers, status, data_out).
`timescale 1ns/1ps
module tb_cpu_exec_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       rf_write;
    logic [3:0] rf_w_reg, rf_r_reg1, rf_r_reg2;
    logic [7:0] rf_w_d, rf_r_d1, rf_r_d2;
    logic [2:0] alu_op;
    logic [7:0] alu_in1, alu_in2, alu_out;
    logic       alu_c;
    logic [7:0] data_out;
    logic       data_out_valid, status, illegal;
    logic [8:0] alu_full;

    logic [7:0] rf [16] = '{default: 8'h00};

    int ncmp = 0;
    int nfail = 0;

    logic [7:0] mregs [16];
    logic       mstatus;
    logic [7:0] mdout;

    cpu_exec_ctrl_if #(.RA(4), .BW(8)) inst_if ();

    cpu_exec_ctrl dut (
        .clk(clk), .rst(rst), .inst_if(inst_if),
        .rf_write(rf_write), .rf_w_reg(rf_w_reg), .rf_w_d(rf_w_d),
        .rf_r_reg1(rf_r_reg1), .rf_r_reg2(rf_r_reg2), .rf_r_d1(rf_r_d1), .rf_r_d2(rf_r_d2),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_c(alu_c),
        .data_out(data_out), .data_out_valid(data_out_valid), .status(status), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ALU stub: {carry, result}; 000 NOT,001 AND,010 ORA,011 ADD,100 SUB,101 XOR,110 SHL
    function automatic logic [8:0] alu_f(input logic [2:0] p, input logic [7:0] a, input logic [7:0] b);
        case (p)
            3'd0: return {1'b0, ~a};
            3'd1: return {1'b0, a & b};
            3'd2: return {1'b0, a | b};
            3'd3: return {1'b0, a} + {1'b0, b};
            3'd4: return {(a < b), 8'(a - b)};
            3'd5: return {1'b0, a ^ b};
            3'd6: return {a[7], a[6:0], 1'b0};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb alu_full = alu_f(alu_op, alu_in1, alu_in2);
    assign alu_out = alu_full[7:0];
    assign alu_c   = alu_full[8];
    assign rf_r_d1 = rf[rf_r_reg1];
    assign rf_r_d2 = rf[rf_r_reg2];

    always @(posedge clk) if (rf_write) rf[rf_w_reg] <= rf_w_d;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, {24'h0, rf[i]}, {24'h0, mregs[i]});
    endtask

    // Issue one instruction, track its execution, then apply it to the model and compare.
    // b2b: drive in the current cycle; hold: keep the request asserted after handshake;
    // noise: present junk requests while busy (must be ignored).
    task automatic issue(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] r3, input logic [7:0] d,
                         input bit b2b, input bit hold, input bit noise);
        int lat, nw, elat;
        logic [3:0] wreg, ereg;
        logic [7:0] wd, ed;
        logic [8:0] ar;
        bit ew, edov, eill, alu;
        wreg = '0; wd = '0; ereg = '0; ed = '0; ew = 0; edov = 0; eill = 0; alu = 0; elat = 1;
        ar = alu_f(op[2:0], mregs[r2], mregs[r3]);
        if (op == 4'b0000)      begin ew = 1; ereg = r2; ed = mregs[r1]; elat = 2; end
        else if (op == 4'b0001) begin ew = 1; ereg = r1; ed = d; elat = 1; end
        else if (op == 4'b0010) begin edov = 1; elat = 2; end
        else if (op == 4'b0011) begin edov = 1; elat = 1; end
        else if (op[3] && op != 4'b1111) begin alu = 1; ew = 1; ereg = r1; ed = ar[7:0]; elat = 3; end
        else begin eill = 1; elat = 1; end

        if (!b2b) begin
            @(negedge clk);
            chk("dov_pulse_end", data_out_valid, 0);
            chk("illegal_pulse_end", illegal, 0);
        end
        chk("ready_idle", inst_if.inst_ready, 1);
        inst_if.inst_op = op; inst_if.inst_r1 = r1; inst_if.inst_r2 = r2;
        inst_if.inst_r3 = r3; inst_if.inst_data = d; inst_if.inst_valid = 1'b1;
        @(negedge clk);
        if (noise) begin
            inst_if.inst_op = 4'($urandom); inst_if.inst_r1 = 4'($urandom);
            inst_if.inst_r2 = 4'($urandom); inst_if.inst_r3 = 4'($urandom);
            inst_if.inst_data = 8'($urandom);
        end else if (!hold) inst_if.inst_valid = 1'b0;
        lat = 0; nw = 0;
        while (inst_if.inst_ready !== 1'b1 && lat < 8) begin
            if (alu && lat == 1) begin
                chk("ex_alu_op", alu_op, op[2:0]);
                chk("ex_alu_in1", alu_in1, mregs[r2]);
                chk("ex_alu_in2", alu_in2, mregs[r3]);
            end
            if (rf_write === 1'b1) begin nw++; wreg = rf_w_reg; wd = rf_w_d; end
            lat++;
            @(negedge clk);
        end
        if (noise) inst_if.inst_valid = 1'b0;

        // Architectural effect of the instruction
        if (op == 4'b0000)      mregs[r2] = mregs[r1];
        else if (op == 4'b0001) mregs[r1] = d;
        else if (op == 4'b0010) mdout = mregs[r1];
        else if (op == 4'b0011) mdout = {7'b0, mstatus};
        else if (alu) begin mregs[r1] = ar[7:0]; mstatus = ar[8]; end

        chk("latency", lat, elat);
        chk("rf_write_cycles", nw, ew ? 1 : 0);
        if (ew) begin
            chk("rf_w_reg", wreg, ereg);
            chk("rf_w_d", wd, ed);
        end
        chk("data_out_valid", data_out_valid, edov);
        chk("illegal", illegal, eill);
        chk("data_out", data_out, mdout);
        chk("status", status, mstatus);
        chk_regs("rf_contents");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mstatus = 1'b0; mdout = 8'h00;
        inst_if.inst_valid = 1'b0; inst_if.inst_op = '0; inst_if.inst_r1 = '0;
        inst_if.inst_r2 = '0; inst_if.inst_r3 = '0; inst_if.inst_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", inst_if.inst_ready, 1);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_status", status, 0);
        chk("rst_dov", data_out_valid, 0);
        chk("rst_illegal", illegal, 0);
        rst = 1'b0;

        // LDB r3,0xA5 then STB r3
        issue(4'b0001, 4'd3, 4'd0, 4'd0, 8'hA5, 0, 0, 0);
        issue(4'b0010, 4'd3, 4'd0, 4'd0, 8'h00, 0, 0, 0);
        chk("stb_value", data_out, 8'hA5);
        // LDB r1,F0; LDB r2,20; ADD r0<=r1+r2; RDS
        issue(4'b0001, 4'd1, 4'd0, 4'd0, 8'hF0, 0, 0, 0);
        issue(4'b0001, 4'd2, 4'd0, 4'd0, 8'h20, 1, 0, 0);
        issue(4'b1011, 4'd0, 4'd1, 4'd2, 8'h00, 0, 0, 0);
        chk("add_result", rf[0], 8'h10);
        chk("add_status", status, 1);
        issue(4'b0011, 4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 0);
        chk("rds_value", data_out, 8'h01);
        // SUB and AND on 0x05 / 0x07
        issue(4'b0001, 4'd1, 4'd0, 4'd0, 8'h05, 0, 0, 0);
        issue(4'b0001, 4'd2, 4'd0, 4'd0, 8'h07, 0, 0, 0);
        issue(4'b1100, 4'd4, 4'd1, 4'd2, 8'h00, 0, 0, 0);
        chk("sub_result", rf[4], 8'hFE);
        chk("sub_borrow", status, 1);
        issue(4'b1001, 4'd5, 4'd1, 4'd2, 8'h00, 1, 0, 0);
        chk("and_result", rf[5], 8'h05);
        chk("and_status", status, 0);
        // Valid held: LDB r1,3C then MVR r2<=r1 taken straight after LDB writeback
        issue(4'b0001, 4'd1, 4'd0, 4'd0, 8'h3C, 0, 1, 0);
        issue(4'b0000, 4'd1, 4'd2, 4'd0, 8'h00, 1, 0, 0);
        chk("mvr_result", rf[2], 8'h3C);
        // Illegal opcodes, including a destination-equals-source ALU op around them
        issue(4'b0101, 4'd7, 4'd7, 4'd7, 8'h99, 0, 0, 0);
        issue(4'b1111, 4'd6, 4'd1, 4'd1, 8'h11, 1, 0, 0);
        issue(4'b1011, 4'd1, 4'd1, 4'd1, 8'h00, 1, 0, 0);
        chk("self_add", rf[1], 8'h78);

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rop = 4'b0001;
            issue(rop, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom),
                  1'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
        end

        // Reset during EX of an ADD: no write, status/data_out cleared
        issue(4'b0001, 4'd1, 4'd0, 4'd0, 8'hF0, 0, 0, 0);
        issue(4'b0001, 4'd2, 4'd0, 4'd0, 8'h20, 0, 0, 0);
        issue(4'b1011, 4'd0, 4'd1, 4'd2, 8'h00, 0, 0, 0);
        issue(4'b0010, 4'd1, 4'd0, 4'd0, 8'h00, 0, 0, 0);
        mregs[6] = 8'h5A;
        issue(4'b0001, 4'd6, 4'd0, 4'd0, 8'h5A, 0, 0, 0);
        @(negedge clk);
        inst_if.inst_op = 4'b1011; inst_if.inst_r1 = 4'd6; inst_if.inst_r2 = 4'd1;
        inst_if.inst_r3 = 4'd2; inst_if.inst_valid = 1'b1;
        @(negedge clk);
        inst_if.inst_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_ex_op", alu_op, 3'b011);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rf_write", rf_write, 0);
        chk("mid_rst_ready", inst_if.inst_ready, 1);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_status", status, 0);
        mstatus = 1'b0; mdout = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_regs("rf_after_reset");
        issue(4'b0011, 4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 0);
        chk("rds_after_reset", data_out, 8'h00);
        issue(4'b1011, 4'd3, 4'd1, 4'd2, 8'h00, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
Multi-cycle execution controller for the 8-bit CPU. It sequences the 16x8 register file and the 3-bit-op ALU. It accepts one decoded instruction at a time over a valid/ready handshake, drives the RF read and write ports and the ALU, and captures results. It also owns the processor status bit (ALU carry) and the registered data output. It sits between the top-level pin decode and the reg_file/alu instances.

Parameters:
BIT_WIDTH_REG, 8, datapath width
REG_COUNT, 16, register count; address width RA = $clog2(REG_COUNT) = 4

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
inst_valid  in  1  instruction present
inst_ready  out  1  controller can accept; high only in IDLE
inst_op  in  4  opcode: 0000 MVR, 0001 LDB, 0010 STB, 0011 RDS, 1ppp ALU op ppp
inst_r1  in  RA  MVR/STB source, LDB/ALU destination
inst_r2  in  RA  MVR destination, ALU source A
inst_r3  in  RA  ALU source B
inst_data  in  8  LDB immediate
rf_write  out  1  RF write enable
rf_w_reg  out  RA  RF write address
rf_w_d  out  8  RF write data
rf_r_reg1  out  RA  RF read address 1
rf_r_reg2  out  RA  RF read address 2
rf_r_d1  in  8  RF read data 1 (combinational read)
rf_r_d2  in  8  RF read data 2
alu_op  out  3  ALU operation
alu_in1  out  8  ALU operand A
alu_in2  out  8  ALU operand B
alu_out  in  8  ALU result (combinational)
alu_c  in  1  ALU carry/borrow
data_out  out  8  registered output byte
data_out_valid  out  1  one-cycle pulse when data_out updated
status  out  1  processor status (last ALU carry)
illegal  out  1  one-cycle pulse on an illegal opcode retire

Behaviour:
- Reset (async): state IDLE. The latched instruction fields, operand registers A/B, result register, data_out, status, data_out_valid and illegal all go to 0. rf_write goes to 0 immediately.
- Reset mid-instruction aborts it: no RF write, no status or data_out change.
- FSM states: IDLE, RD, EX, WB.
- IDLE: inst_ready=1. On inst_valid&inst_ready, latch op/r1/r2/r3/data.
  - Next state is RD for MVR, STB and ALU ops.
  - Next state is WB for LDB, RDS and illegal opcodes (0100-0111, 1111).
- Inputs are sampled only at the handshake edge. inst_valid outside IDLE is ignored.
- RD: rf_r_reg1 = MVR/STB ? r1 : r2; rf_r_reg2 = r3.
  - At exit, operand A <= rf_r_d1 and operand B <= rf_r_d2.
  - Next state is EX for ALU ops, WB otherwise.
- EX: alu_op = op[2:0]; alu_in1 = A; alu_in2 = B.
  - At exit, result <= alu_out and carry_q <= alu_c. Next state WB.
- Outside EX, alu_op/alu_in1/alu_in2 hold the latched op[2:0], A and B. No other datapath effect.
- WB: rf_write=1 only for MVR, LDB and legal ALU ops.
  - rf_w_reg: r2 for MVR, r1 for LDB and ALU.
  - rf_w_d: A for MVR, latched data for LDB, result for ALU.
  - The write commits at the WB exit edge. Next state IDLE.
- At WB exit:
  - STB: data_out <= A.
  - RDS: data_out <= {7'b0, status}.
  - In both cases data_out_valid=1 for the following cycle.
  - ALU op: status <= carry_q (0 for NOT/AND/ORA/XOR; borrow for SUB).
  - Illegal: illegal=1 for the following cycle.
- Outside WB: rf_write=0. rf_w_reg and rf_w_d hold their WB-selected values; rf_r_reg1/2 hold the RD selection.
- Latency (cycles inst_ready is low after handshake):
  - LDB, RDS, illegal: 1.
  - MVR, STB: 2.
  - ALU: 3.
- Back-to-back issue:
  - A new instruction may be accepted in the cycle data_out_valid/illegal is high.
  - The RF write of instruction N commits before instruction N+1 reaches RD, so there are no RAW hazards and no forwarding is needed.
- Destination may equal a source: operands are captured in RD and the result is written in WB.
- data_out and status hold their values across all other instructions.

Test Plan:
- Reset: assert rst while in EX of ADD -> same cycle rf_write=0, inst_ready=1; data_out=0x00, status=0; RF contents unchanged.
- LDB r3,0xA5 then STB r3 -> WB cycle shows rf_write=1, rf_w_reg=3, rf_w_d=0xA5; data_out=0xA5 with a 1-cycle data_out_valid; inst_ready low 1 then 2 cycles.
- LDB r1,0xF0; LDB r2,0x20; ADD r0<=r1+r2 -> EX alu_op=011, WB rf_w_d=0x10, status=1; RDS -> data_out=0x01.
- r1=0x05, r2=0x07: SUB r4<=r1-r2 -> r4=0xFE, status=1; then AND r5<=r1&r2 -> r5=0x05, status=0.
- inst_valid held high: LDB r1,0x3C immediately followed by MVR r2<=r1 -> r2=0x3C; second handshake occurs the cycle after LDB WB.
- Opcode 0101 -> illegal pulse 1 cycle; no rf_write; data_out and status unchanged; inst_ready low exactly 1 cycle.
